// File: rtl/label_ptr_resolver.sv
// ============================================================================
// Module      : label_ptr_resolver
// Description : Two-stage valid/ready pointer-dereference pipeline. It looks up
//               a label in the label table, checks type and bounds, and returns
//               a resolved data-memory address or an error code.
//               Optional error statistics are enabled by LBRES_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module label_ptr_resolver #(
    parameter int LBID_W = 12,
    parameter int ADDR_W = 16,
    parameter int TYP_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LBID_W-1:0] req_lbid,
    input  logic [ADDR_W-1:0] req_ofs,
    input  logic [TYP_W-1:0]  req_typ,
    output logic [LBID_W-1:0] lbt_lbid,
    input  logic [TYP_W-1:0]  lbt_typ,
    input  logic [ADDR_W-1:0] lbt_base,
    input  logic [ADDR_W-1:0] lbt_count,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [TYP_W-1:0]  rsp_typ,
    output logic [1:0]        rsp_err
`ifdef LBRES_STATS_EN
    ,
    output logic [15:0]       err_cnt,
    input  logic              stat_clr
`endif
);

    localparam logic [1:0] c_ERR_OK     = 2'd0;
    localparam logic [1:0] c_ERR_UNDEF  = 2'd1;
    localparam logic [1:0] c_ERR_TYPE   = 2'd2;
    localparam logic [1:0] c_ERR_BOUNDS = 2'd3;

    logic              r_s1_valid;
    logic [LBID_W-1:0] r_s1_lbid;
    logic [ADDR_W-1:0] r_s1_ofs;
    logic [TYP_W-1:0]  r_s1_typ;

    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [TYP_W-1:0]  r_rsp_typ;
    logic [1:0]        r_rsp_err;

    logic              w_s2_take;
    logic              w_s1_load;
    logic              w_s2_load;
    logic [1:0]        w_err;
    logic [ADDR_W-1:0] w_sum;

    assign w_s2_take = !r_rsp_valid || rsp_ready;
    assign req_ready = !r_s1_valid || w_s2_take;
    assign w_s1_load = req_valid && req_ready;
    assign w_s2_load = r_s1_valid && w_s2_take;

    // Table read index comes straight from S1 so the lookup is sampled at S2 load.
    assign lbt_lbid  = r_s1_lbid;
    assign w_sum     = lbt_base + r_s1_ofs;

    always_comb begin
        w_err = c_ERR_OK;
        if (lbt_count == '0) begin
            w_err = c_ERR_UNDEF;
        end else if ((r_s1_typ != '0) && (lbt_typ != r_s1_typ)) begin
            w_err = c_ERR_TYPE;
        end else if (r_s1_ofs >= lbt_count) begin
            w_err = c_ERR_BOUNDS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_lbid  <= '0;
            r_s1_ofs   <= '0;
            r_s1_typ   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
            r_s1_lbid  <= req_lbid;
            r_s1_ofs   <= req_ofs;
            r_s1_typ   <= req_typ;
        end else if (w_s2_take) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_typ   <= '0;
            r_rsp_err   <= c_ERR_OK;
        end else if (w_s2_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_addr  <= (w_err == c_ERR_OK) ? w_sum : '0;
            r_rsp_typ   <= lbt_typ;
            r_rsp_err   <= w_err;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_typ   = r_rsp_typ;
    assign rsp_err   = r_rsp_err;

`ifdef LBRES_STATS_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (stat_clr) begin
            r_err_cnt <= '0;
        end else if (r_rsp_valid && rsp_ready && (r_rsp_err != c_ERR_OK)
                     && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire
